// File: rtl/debounce_if.sv
// Debounce controller bus: synchronized button levels in, debounced level
// and press/release event pulses out, one bit per channel.
interface debounce_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] sync_btn;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (
    output sync_btn,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  sync_btn,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/debounce_ctrl.sv
// Multi-channel button debouncer. Each channel is an independent
// IDLE/ARM/HELD/REL machine with its own stability counter. It has
// registered level, press and release outputs, and an optional
// auto-repeat of the press pulse while the button is held.
module debounce_ctrl #(
  parameter int N_BTN         = 4,
  parameter int DEBNC_CYCLES  = 4,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  debounce_if.slave bus
);

  localparam int            CW       = $clog2(DEBNC_CYCLES + 1);
  localparam logic [CW-1:0] DEB_TC   = CW'(DEBNC_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBNC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_HELD = 2'd2,
    S_REL  = 2'd3
  } state_t;

  // Stability counter increment. It stops at the terminal count and never wraps.
  function automatic logic [CW-1:0] deb_inc(input logic [CW-1:0] c);
    return (c >= DEB_TC) ? DEB_TC : c + CW'(1);
  endfunction

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          level_q, press_q, release_q;
    logic          level_nxt, press_nxt, release_nxt;
    logic          btn;
    logic          rpt_hit;

    assign btn = bus.sync_btn[i];

    // Channel state, stability counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= S_IDLE;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        level_q   <= level_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    // Next-state logic. The edge that would bring the counter to
    // DEBNC_CYCLES is the accepting edge, so the counter only holds
    // values 0..DEBNC_CYCLES-1.
    always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      level_nxt   = level_q;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
        S_IDLE: begin
          if (btn) begin
            state_nxt = S_ARM;
            cnt_nxt   = '0;
          end
        end
        S_ARM: begin
          if (!btn) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nxt = S_HELD;
            cnt_nxt   = '0;
            level_nxt = 1'b1;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = deb_inc(cnt);
          end
        end
        S_HELD: begin
          if (!btn) begin
            state_nxt = S_REL;
            cnt_nxt   = '0;
          end else if (rpt_hit) begin
            press_nxt = 1'b1;
          end
        end
        S_REL: begin
          if (btn) begin
            state_nxt = S_HELD;
            cnt_nxt   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nxt   = S_IDLE;
            cnt_nxt     = '0;
            level_nxt   = 1'b0;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt = deb_inc(cnt);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    if (REPEAT_CYCLES > 0) begin : g_rpt
      localparam int            RW       = $clog2(REPEAT_CYCLES + 1);
      localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

      logic [RW-1:0] rpt;
      logic          rpt_run;
      logic          rpt_clr;

      // The counter advances only on held-and-still-pressed cycles. It is
      // frozen through REL, and it is zeroed in ARM (entry to HELD) and on
      // any move to IDLE.
      assign rpt_run = (state == S_HELD) && btn;
      assign rpt_clr = (state == S_ARM) || (state_nxt == S_IDLE);
      assign rpt_hit = rpt_run && (rpt == RPT_LAST);

      // Auto-repeat period counter
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rpt <= '0;
        end else if (rpt_clr) begin
          rpt <= '0;
        end else if (rpt_run) begin
          rpt <= (rpt == RPT_LAST) ? '0 : rpt + RW'(1);
        end
      end
    end else begin : g_no_rpt
      assign rpt_hit = 1'b0;
    end

    assign bus.btn_level[i]   = level_q;
    assign bus.btn_press[i]   = press_q;
    assign bus.btn_release[i] = release_q;
  end

endmodule
